seq_run_classifier: RTL
=======================

SEQ_RUN_CLASSIFIER -- requirements
Module: seq_run_classifier

Interface
REQ-001 The block SHALL have parameter DEPTH, default 3, meaning the number of FSM states S0..S(DEPTH-1); legal range 2..16.
REQ-002 The block SHALL have parameter CW, default 8, meaning the event-counter width; legal range 1..32.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: advance enable; when 0 the FSM holds and Z1/Z2 are forced to 0.
REQ-006 The block SHALL have port X, input, 1 bit: the serial data bit being classified.
REQ-007 The block SHALL have port overlap, input, 1 bit: mode select; 0 = restart after each decision, 1 = overlapping runs.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear of both event counters.
REQ-009 The block SHALL have port state_oh, output, DEPTH bits: one-hot Moore state; bit k = 1 exactly when in state Sk.
REQ-010 The block SHALL have port Z1, output, 1 bit: Mealy "run broken at final state" event.
REQ-011 The block SHALL have port Z2, output, 1 bit: Mealy "run extended past final state" event.
REQ-012 The block SHALL have port z1_cnt, output, CW bits: saturating count of Z1 events.
REQ-013 The block SHALL have port z2_cnt, output, CW bits: saturating count of Z2 events.

Function
REQ-014 In Sk with k < DEPTH-1, the FSM SHALL move to S(k+1) when en=1 and X=1, move to S0 when en=1 and X=0, and hold when en=0.
REQ-015 In Sk with k < DEPTH-1, Z1 and Z2 SHALL both be 0.
REQ-016 In S(DEPTH-1), Z2 SHALL equal en AND X, and Z1 SHALL equal en AND NOT X, combinationally in the same cycle with no register.
REQ-017 In S(DEPTH-1) with en=1 and overlap=0, next state SHALL be S0 regardless of X.
REQ-018 In S(DEPTH-1) with en=1 and overlap=1, next state SHALL be S(DEPTH-1) if X=1, else S0.
REQ-019 In S(DEPTH-1) with en=0, the FSM SHALL hold.
REQ-020 Z1 and Z2 SHALL never be 1 in the same cycle.
REQ-021 state_oh SHALL be decoded from the present state only (Moore) and SHALL always be exactly one-hot.
REQ-022 z1_cnt SHALL increment by 1 at the clock edge ending a cycle with Z1=1, and SHALL hold at 2^CW-1 once reached (no wrap).
REQ-023 z2_cnt SHALL follow the same rules as z1_cnt, applied to Z2.
REQ-024 Counter updates SHALL be visible on the cycle after the event (1-cycle latency).
REQ-025 clr=1 SHALL set both counters to 0 at the next edge and SHALL take priority over a simultaneous increment.
REQ-026 clr SHALL NOT affect the FSM.
REQ-027 overlap SHALL be sampled every cycle; changing it mid-run SHALL affect only the next decision taken in S(DEPTH-1).
REQ-028 With DEPTH=3, overlap=0 and en=1, behaviour SHALL match the team's existing three-state detector: Ya/Yb/Yc correspond to state_oh[0]/[1]/[2].

Reset
REQ-029 On reset=1 at a clock edge, the block SHALL set state to S0 (state_oh = 1 in bit 0), z1_cnt = 0 and z2_cnt = 0.
REQ-030 Reset SHALL override en, clr and any in-progress run, including a run held in S(DEPTH-1).
REQ-031 While reset=1, Z1 and Z2 SHALL still be decoded from the present state per REQ-016.

Structure
REQ-032 The shared package seq_pkg SHALL hold the DEPTH_DEFAULT and CW_DEFAULT constants.
REQ-033 The state register SHALL be a binary index of width $clog2(DEPTH), declared locally; it SHALL NOT be a package enum, because its width is parameter-dependent.
REQ-034 Each counter SHALL be one instance of the sub-module sat_counter (parameter W; ports clk, reset, clr, inc, q), instantiated twice.

Verification
REQ-035 DEPTH=3, overlap=0, en=1, X=1,1,1,0 -> state_oh 001,010,100,001; Z2=1 in cycle 3; z2_cnt=1 in cycle 4.
REQ-036 DEPTH=3, overlap=1, X=1,1,1,1,0 -> Z2=1 in cycles 3 and 4, Z1=1 in cycle 5; z2_cnt=2 and z1_cnt=1 afterwards.
REQ-037 DEPTH=4, en toggled 1,0,1,0,1,1 with X held at 1 -> state advances only on en=1 cycles; Z2 asserts only in the cycle that is in S3 with en=1.
REQ-038 CW=2, eight Z1 events -> z1_cnt reads 1,2,3,3,3...; clr asserted on the same cycle as a Z1 event -> counter reads 0 on the next cycle.
REQ-039 Reset asserted while in S2 with z2_cnt=5 -> next cycle state_oh=001, both counters 0.
REQ-040 Random X/en/overlap for 10k cycles -> state_oh always one-hot, Z1 AND Z2 never both 1, counters match a reference model.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the run classifier slice.
// Default depth and counter width used by the top.
package seq_pkg;

  localparam int DEPTH_DEFAULT = 3;
  localparam int CW_DEFAULT    = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over a simultaneous increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seq_run_classifier.sv
// Classifies runs of 1s on X: counts runs that break at the
// final state (Z1) and runs that extend past it (Z2).
module seq_run_classifier
  import seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = CW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             X,
  input  logic             overlap,
  input  logic             clr,
  output logic [DEPTH-1:0] state_oh,
  output logic             Z1,
  output logic             Z2,
  output logic [CW-1:0]    z1_cnt,
  output logic [CW-1:0]    z2_cnt
);

  localparam int SW = $clog2(DEPTH);
  localparam logic [SW-1:0] LAST = SW'(DEPTH - 1);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          z1;
  logic          z2;

  always_comb begin
    state_d = state_q;
    z1      = 1'b0;
    z2      = 1'b0;
    if (state_q == LAST) begin
      z1 = en & ~X;
      z2 = en & X;
      // overlap keeps a still-running sequence parked in the final state
      if (en) begin
        state_d = (overlap && X) ? LAST : '0;
      end
    end else if (en) begin
      state_d = X ? state_q + SW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_oh = '0;
    for (int k = 0; k < DEPTH; k++) begin
      state_oh[k] = (state_q == SW'(k));
    end
  end

  assign Z1 = z1;
  assign Z2 = z2;

  sat_counter #(.W(CW)) u_z1_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (z1),
    .q     (z1_cnt)
  );

  sat_counter #(.W(CW)) u_z2_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (z2),
    .q     (z2_cnt)
  );

endmodule
